// File: rtl/apb_reg_bank_pkg.sv
// ---------------------------------------------------------------------------
// apb_reg_bank_pkg
//   Shared types and helpers for the APB4 register bank.
//   - state_e         : completer FSM states (IDLE, SETUP, ACCESS)
//   - strb_merge()    : byte-strobe merge of write data into an existing word
//   - MAX_WAIT_STATES : upper bound for the WAIT_STATES parameter
// ---------------------------------------------------------------------------
package apb_reg_bank_pkg;

  localparam int MAX_WAIT_STATES = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  // Bytes whose strobe is set take the new data; the rest keep the old word.
  function automatic logic [31:0] strb_merge(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_reg_bank_wait_ctr.sv
// ---------------------------------------------------------------------------
// apb_reg_bank_wait_ctr
//   Loadable down-counter that paces the ACCESS phase.
//   Ports:
//     clk      : clock, rising edge
//     rst      : synchronous active-high reset, clears the count
//     load     : load load_val (has priority over dec)
//     load_val : value to load
//     dec      : decrement by one; holds at zero
//     cnt      : current count
//     zero     : high when cnt == 0
// ---------------------------------------------------------------------------
module apb_reg_bank_wait_ctr #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/apb_reg_bank.sv
// ---------------------------------------------------------------------------
// apb_reg_bank
//   APB4 completer with NUM_REGS 32-bit read/write registers, byte-strobe
//   writes, WAIT_STATES access-phase wait cycles and PSLVERR on out-of-range
//   or misaligned accesses. All registers are exported on regs_o.
//   Ports:
//     PCLK    : clock, rising edge
//     PRESET  : synchronous active-high reset
//     PADDR   : byte address; register index is PADDR[ADDR_WIDTH-1:2]
//     PSEL    : select
//     PENABLE : access phase
//     PWRITE  : 1 = write, 0 = read
//     PWDATA  : write data
//     PSTRB   : byte write strobes (writes only)
//     PREADY  : transfer completion
//     PRDATA  : read data, nonzero only in a successful read completion
//     PSLVERR : error, only with PREADY
//     regs_o  : register i at bits [32*i+31:32*i]
//   Outputs are decoded from registered state only; the request is captured
//   into holding registers when the FSM leaves IDLE.
// ---------------------------------------------------------------------------
module apb_reg_bank
  import apb_reg_bank_pkg::*;
#(
  parameter int          NUM_REGS    = 4,
  parameter int          ADDR_WIDTH  = 4,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [31:0]             PWDATA,
  input  logic [3:0]              PSTRB,
  output logic                    PREADY,
  output logic [31:0]             PRDATA,
  output logic                    PSLVERR,
  output logic [32*NUM_REGS-1:0]  regs_o
);

  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  state_e           state;
  logic [31:0]      regs [NUM_REGS];

  logic [IDX_W-1:0] paddr_idx;
  logic             aligned;
  logic             in_range;
  logic             setup_req;
  logic             ctr_load;
  logic             ctr_dec;
  logic             ctr_zero;
  logic [CNT_W-1:0] ctr_val;
  logic             complete;

  // Request holding registers, captured on IDLE -> SETUP
  logic [SEL_W-1:0] idx_p0;
  logic             write_p0;
  logic             err_p0;
  logic [31:0]      wdata_p0;
  logic [3:0]       strb_p0;

  assign paddr_idx = PADDR[ADDR_WIDTH-1:2];
  assign aligned   = (PADDR[1:0] == 2'b00);
  assign in_range  = ({{(32-IDX_W){1'b0}}, paddr_idx} < NUM_REGS);

  // PENABLE high in IDLE is a protocol violation and never starts a transfer.
  assign setup_req = PSEL && !PENABLE;
  assign ctr_load  = (state == IDLE) && setup_req;
  assign ctr_dec   = (state == ACCESS) && PSEL && PENABLE && !ctr_zero;
  assign complete  = (state == ACCESS) && ctr_zero;

  apb_reg_bank_wait_ctr #(
    .WIDTH(CNT_W)
  ) u_wait_ctr (
    .clk      (PCLK),
    .rst      (PRESET),
    .load     (ctr_load),
    .load_val (CNT_W'(WAIT_STATES)),
    .dec      (ctr_dec),
    .cnt      (ctr_val),
    .zero     (ctr_zero)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (setup_req) state <= SETUP;
        SETUP:   state <= ACCESS;
        // Completion wins over an abort once the count has reached zero,
        // since PREADY is already being shown in that cycle.
        ACCESS:  if (complete || !PSEL) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Holding registers carry no reset: they are only observed while the
  // FSM is past IDLE, and every transfer reloads them.
  always_ff @(posedge PCLK) begin
    if (ctr_load) begin
      idx_p0   <= paddr_idx[SEL_W-1:0];
      write_p0 <= PWRITE;
      err_p0   <= !aligned || !in_range;
      wdata_p0 <= PWDATA;
      strb_p0  <= PSTRB;
    end
  end

  // Register array: write commits on the completion edge
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RESET_VALUE;
      end
    end else if (complete && write_p0 && !err_p0) begin
      regs[idx_p0] <= strb_merge(regs[idx_p0], wdata_p0, strb_p0);
    end
  end

  // Response decode from registered state
  assign PREADY  = complete;
  assign PSLVERR = complete && err_p0;
  assign PRDATA  = (complete && !write_p0 && !err_p0) ? regs[idx_p0] : 32'h0;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_export
    assign regs_o[32*g +: 32] = regs[g];
  end

  logic unused_ctr;
  assign unused_ctr = ^ctr_val;

endmodule

// File: tb/tb_apb_reg_bank.sv
// ---------------------------------------------------------------------------
// tb_apb_reg_bank
//   Directed bench for apb_reg_bank. Two instances share the bus wires and
//   are selected by their own PSEL: dut0 (NUM_REGS=4, no wait states, reset
//   value 0) and dut1 (NUM_REGS=4, 3 wait states, nonzero reset value).
//   Access-phase cycle counts include the cycle PREADY is seen.
// ---------------------------------------------------------------------------
module tb_apb_reg_bank;

  localparam logic [31:0] RV1 = 32'hA5A5_0F0F;

  logic         clk = 1'b0;
  logic         preset;
  logic [4:0]   paddr;
  logic         penable;
  logic         pwrite;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic         psel0, psel1;

  logic         pready0, pslverr0, pready1, pslverr1;
  logic [31:0]  prdata0, prdata1;
  logic [127:0] regs0, regs1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_reg_bank #(
    .NUM_REGS(4), .ADDR_WIDTH(5), .WAIT_STATES(0), .RESET_VALUE(32'h0)
  ) u_dut0 (
    .PCLK(clk), .PRESET(preset), .PADDR(paddr), .PSEL(psel0),
    .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
    .PREADY(pready0), .PRDATA(prdata0), .PSLVERR(pslverr0), .regs_o(regs0)
  );

  apb_reg_bank #(
    .NUM_REGS(4), .ADDR_WIDTH(5), .WAIT_STATES(3), .RESET_VALUE(RV1)
  ) u_dut1 (
    .PCLK(clk), .PRESET(preset), .PADDR(paddr), .PSEL(psel1),
    .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
    .PREADY(pready1), .PRDATA(prdata1), .PSLVERR(pslverr1), .regs_o(regs1)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transfer on dut t; ncyc counts access-phase cycles up to and
  // including the PREADY cycle (32 means PREADY never came).
  task automatic xfer(input int t, input logic wr, input logic [4:0] addr,
                      input logic [31:0] wd, input logic [3:0] st,
                      output logic [31:0] rd, output logic er, output int ncyc);
    paddr = addr; pwrite = wr; pwdata = wd; pstrb = st; penable = 1'b0;
    if (t == 0) psel0 = 1'b1; else psel1 = 1'b1;
    @(posedge clk); #1;
    penable = 1'b1;
    ncyc = 0; rd = 'x; er = 1'bx;
    while (ncyc < 32) begin
      ncyc++;
      if ((t == 0) ? pready0 : pready1) begin
        rd = (t == 0) ? prdata0 : prdata1;
        er = (t == 0) ? pslverr0 : pslverr1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          n;
    logic        seen;

    preset = 1'b1; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
    pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pready0", pready0, 1'b0);
    chk("rst_prdata0", prdata0, 32'h0);
    chk("rst_pslverr0", pslverr0, 1'b0);
    chk("rst_regs0", regs0, 128'h0);
    chk("rst_pready1", pready1, 1'b0);
    chk("rst_regs1", regs1, {4{RV1}});
    preset = 1'b0;
    @(posedge clk); #1;

    // Full write / read on register 1
    xfer(0, 1'b1, 5'h04, 32'hDEADBEEF, 4'hF, rd, er, n);
    chk("wr4_cycles", n, 2);
    chk("wr4_err", er, 1'b0);
    chk("wr4_prdata", rd, 32'h0);
    chk("wr4_regs", regs0, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0});
    xfer(0, 1'b0, 5'h04, 32'h0, 4'h0, rd, er, n);
    chk("rd4_cycles", n, 2);
    chk("rd4_data", rd, 32'hDEADBEEF);
    chk("rd4_err", er, 1'b0);

    // Partial strobe
    xfer(0, 1'b1, 5'h04, 32'h11223344, 4'b0101, rd, er, n);
    chk("strb_regs", regs0, {32'h0, 32'h0, 32'hDE22BE44, 32'h0});
    xfer(0, 1'b0, 5'h04, 32'h0, 4'h0, rd, er, n);
    chk("strb_rd", rd, 32'hDE22BE44);

    // Errors: out of range and misaligned
    xfer(0, 1'b1, 5'h10, 32'hCAFEF00D, 4'hF, rd, er, n);
    chk("oor_wr_err", er, 1'b1);
    chk("oor_wr_prdata", rd, 32'h0);
    chk("oor_wr_cycles", n, 2);
    xfer(0, 1'b1, 5'h06, 32'hCAFEF00D, 4'hF, rd, er, n);
    chk("mis_wr_err", er, 1'b1);
    chk("err_regs", regs0, {32'h0, 32'h0, 32'hDE22BE44, 32'h0});
    xfer(0, 1'b0, 5'h06, 32'h0, 4'h0, rd, er, n);
    chk("mis_rd_err", er, 1'b1);
    chk("mis_rd_prdata", rd, 32'h0);
    xfer(0, 1'b0, 5'h1C, 32'h0, 4'h0, rd, er, n);
    chk("oor_rd_err", er, 1'b1);
    chk("pslverr_idle", pslverr0, 1'b0);

    // Protocol violation: PENABLE with PSEL straight from IDLE
    paddr = 5'h08; pwrite = 1'b1; pwdata = 32'h55555555; pstrb = 4'hF;
    psel0 = 1'b1; penable = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      seen = seen | pready0;
    end
    psel0 = 1'b0; penable = 1'b0;
    chk("viol_no_ready", seen, 1'b0);
    chk("viol_regs", regs0, {32'h0, 32'h0, 32'hDE22BE44, 32'h0});
    @(posedge clk); #1;
    xfer(0, 1'b0, 5'h04, 32'h0, 4'h0, rd, er, n);
    chk("post_viol_cycles", n, 2);
    chk("post_viol_rd", rd, 32'hDE22BE44);

    // Wait states: read register 0 of dut1
    xfer(1, 1'b0, 5'h00, 32'h0, 4'h0, rd, er, n);
    chk("ws_rd_cycles", n, 5);
    chk("ws_rd_data", rd, RV1);
    chk("ws_rd_err", er, 1'b0);
    xfer(1, 1'b1, 5'h0C, 32'h0BADC0DE, 4'hF, rd, er, n);
    chk("ws_wr_cycles", n, 5);
    chk("ws_wr_regs", regs1, {32'h0BADC0DE, RV1, RV1, RV1});

    // Abort during a wait state of a write
    paddr = 5'h08; pwrite = 1'b1; pwdata = 32'h12121212; pstrb = 4'hF;
    penable = 1'b0; psel1 = 1'b1;
    seen = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    repeat (3) begin
      seen = seen | pready1;
      @(posedge clk); #1;
    end
    psel1 = 1'b0; penable = 1'b0;
    repeat (6) begin
      seen = seen | pready1;
      @(posedge clk); #1;
    end
    chk("abort_no_ready", seen, 1'b0);
    chk("abort_regs", regs1, {32'h0BADC0DE, RV1, RV1, RV1});
    xfer(1, 1'b0, 5'h08, 32'h0, 4'h0, rd, er, n);
    chk("post_abort_cycles", n, 5);
    chk("post_abort_rd", rd, RV1);

    // Reset during the 2nd wait cycle of a write
    paddr = 5'h04; pwrite = 1'b1; pwdata = 32'h12345678; pstrb = 4'hF;
    penable = 1'b0; psel1 = 1'b1;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    preset = 1'b1;
    @(posedge clk); #1;
    chk("rstw_pready", pready1, 1'b0);
    chk("rstw_regs1", regs1, {4{RV1}});
    chk("rstw_regs0", regs0, 128'h0);
    preset = 1'b0; psel1 = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    xfer(1, 1'b0, 5'h04, 32'h0, 4'h0, rd, er, n);
    chk("rstw_rd_cycles", n, 5);
    chk("rstw_rd", rd, RV1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
